iob_uart16550_stream: RTL

//   IOb-bus master sitting directly upstream of iob_uart16550: turns a byte-stream TX input and a byte-stream RX

---
 rtl/iob_uart16550_stream.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/iob_uart16550_stream.sv
// iob_uart16550_stream: IOb master that configures an iob_uart16550 core and bridges
// valid/ready byte streams to its THR/RBR registers by polling LSR.
module iob_uart16550_stream #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DIV      = 54,
  parameter int TX_BURST = 16
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [7:0]          s_data_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  output logic [7:0]          m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                init_done_o,
  output logic                iob_avalid_o,
  output logic [ADDR_W-1:0]   iob_addr_o,
  output logic [DATA_W-1:0]   iob_wdata_o,
  output logic [DATA_W/8-1:0] iob_wstrb_o,
  input  logic                iob_ready_i,
  input  logic                iob_rvalid_i,
  input  logic [DATA_W-1:0]   iob_rdata_i
);
  localparam int SW = DATA_W / 8;
  localparam logic [15:0] DIV16 = 16'(DIV);
  localparam logic [4:0] BURST = 5'(TX_BURST);
  typedef enum logic [3:0] {
    ST_INIT, ST_INIT_REQ, ST_POLL, ST_LSR_REQ, ST_LSR_WAIT,
    ST_RBR_REQ, ST_RBR_WAIT, ST_THR, ST_THR_REQ
  } state_t;
  state_t state, state_n;
  logic [2:0] step, step_n;
  logic [4:0] burst, burst_n;
  logic dr_q, dr_n, rx_full, rx_full_n, done_n, avalid_n, req_go, req_w;
  logic [7:0] rx_data, rx_data_n, rd_byte, init_d, req_d;
  logic [ADDR_W-1:0] addr_n, init_a, req_a;
  logic [DATA_W-1:0] wdata_n;
  logic [SW-1:0] wstrb_n;
  assign s_ready_o = state == ST_THR && s_valid_i;
  assign m_valid_o = rx_full;
  assign m_data_o  = rx_data;
  assign rd_byte   = 8'(iob_rdata_i >> {iob_addr_o[1:0], 3'b000});
  assign init_a = step == 3'd0 ? ADDR_W'(3) : step == 3'd1 ? ADDR_W'(0) :
                  step == 3'd2 ? ADDR_W'(1) : step == 3'd3 ? ADDR_W'(3) : ADDR_W'(2);
  assign init_d = step == 3'd0 ? 8'h83 : step == 3'd1 ? DIV16[7:0] :
                  step == 3'd2 ? DIV16[15:8] : step == 3'd3 ? 8'h03 : 8'h07;
  always_comb begin
    state_n   = state;
    step_n    = step;
    burst_n   = burst;
    dr_n      = dr_q;
    rx_data_n = rx_data;
    rx_full_n = rx_full & ~m_ready_i;
    done_n    = init_done_o;
    avalid_n  = iob_avalid_o;
    addr_n    = iob_addr_o;
    wdata_n   = iob_wdata_o;
    wstrb_n   = iob_wstrb_o;
    req_go    = 1'b0;
    req_w     = 1'b0;
    req_a     = '0;
    req_d     = '0;
    case (state)
      ST_INIT: begin
        {req_go, req_w, req_a, req_d} = {2'b11, init_a, init_d};
        state_n = ST_INIT_REQ;
      end
      ST_INIT_REQ: if (iob_ready_i) begin
        avalid_n = 1'b0;
        step_n   = step + 3'd1;
        done_n   = step == 3'd4;
        state_n  = step == 3'd4 ? ST_POLL : ST_INIT;
      end
      ST_POLL: begin
        {req_go, req_a} = {1'b1, ADDR_W'(5)};
        state_n = ST_LSR_REQ;
      end
      ST_LSR_REQ: if (iob_ready_i) {avalid_n, state_n} = {1'b0, ST_LSR_WAIT};
      ST_LSR_WAIT: if (iob_rvalid_i) begin
        dr_n    = rd_byte[0];
        burst_n = rd_byte[5] ? BURST : burst;
        // a full holding register leaves DR pending in the UART FIFO
        if (rd_byte[0] && !rx_full) begin
          req_go  = 1'b1;
          state_n = ST_RBR_REQ;
        end else
          state_n = burst_n != 5'd0 && s_valid_i ? ST_THR : ST_POLL;
      end
      ST_RBR_REQ: if (iob_ready_i) {avalid_n, state_n} = {1'b0, ST_RBR_WAIT};
      ST_RBR_WAIT: if (iob_rvalid_i) begin
        rx_data_n = rd_byte;
        rx_full_n = 1'b1;
        dr_n      = 1'b0;
        state_n   = ST_POLL;
      end
      ST_THR: if (s_valid_i) begin
        {req_go, req_w, req_d} = {2'b11, s_data_i};
        burst_n = burst == 5'd0 ? 5'd0 : burst - 5'd1;
        state_n = ST_THR_REQ;
      end else
        state_n = ST_POLL;
      ST_THR_REQ: if (iob_ready_i) begin
        avalid_n = 1'b0;
        state_n  = burst != 5'd0 && s_valid_i && !(dr_q && !rx_full) ? ST_THR : ST_POLL;
      end
      default: state_n = ST_INIT;
    endcase
    if (req_go) begin
      avalid_n = 1'b1;
      addr_n   = req_a;
      wdata_n  = req_w ? DATA_W'(req_d) << {req_a[1:0], 3'b000} : '0;
      wstrb_n  = req_w ? SW'(1) << req_a[1:0] : '0;
    end
  end
  always_ff @(posedge clk_i or posedge arst_i)
    if (arst_i) begin
      state        <= ST_INIT;
      step         <= '0;
      burst        <= '0;
      dr_q         <= 1'b0;
      rx_full      <= 1'b0;
      rx_data      <= '0;
      init_done_o  <= 1'b0;
      iob_avalid_o <= 1'b0;
      iob_addr_o   <= '0;
      iob_wdata_o  <= '0;
      iob_wstrb_o  <= '0;
    end else begin
      state        <= state_n;
      step         <= step_n;
      burst        <= burst_n;
      dr_q         <= dr_n;
      rx_full      <= rx_full_n;
      rx_data      <= rx_data_n;
      init_done_o  <= done_n;
      iob_avalid_o <= avalid_n;
      iob_addr_o   <= addr_n;
      iob_wdata_o  <= wdata_n;
      iob_wstrb_o  <= wstrb_n;
    end
endmodule
